axis_inject_arbiter: RTL

// - Shares one router injection port (axis_in_* of the router wrapper) among NUM_REQ AXIS requesters.
// - Arbitration is packet-granular round-robin: once a requester is granted, its grant holds until its tlast beat is accepted.
// - A registered output stage drives the router injection interface; there is no cross-clock logic, the block runs entirely in clk_noc.

---
 rtl/axis_inject_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/axis_inject_arbiter.sv
// axis_inject_arbiter
//   Shares one router injection port among NUM_REQ AXI-Stream requesters.
//   Arbitration is packet-granular round-robin. A grant is held from the
//   first beat until the requester's tlast beat is accepted. A single
//   registered output stage drives the injection port. The whole block runs
//   in clk_noc and has no clock-domain crossings.
//
//   Build option:
//     INJECT_ARB_STATS_EN - when defined, builds saturating per-requester
//                           counters of accepted packets. When undefined,
//                           pkt_count is tied to zero and stats_clear is
//                           ignored. The port list is the same in both builds.
module axis_inject_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TDATA_WIDTH = 32,
  parameter int TID_WIDTH   = 2,
  parameter int TDEST_WIDTH = 4,
  parameter int STAT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  // Requester side, packed with requester i at slice i
  input  logic [NUM_REQ-1:0]               s_axis_tvalid,
  output logic [NUM_REQ-1:0]               s_axis_tready,
  input  logic [NUM_REQ*TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_REQ-1:0]               s_axis_tlast,
  input  logic [NUM_REQ*TID_WIDTH-1:0]     s_axis_tid,
  input  logic [NUM_REQ*TDEST_WIDTH-1:0]   s_axis_tdest,
  // Router injection port
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [TDATA_WIDTH-1:0]           m_axis_tdata,
  output logic                             m_axis_tlast,
  output logic [TID_WIDTH-1:0]             m_axis_tid,
  output logic [TDEST_WIDTH-1:0]           m_axis_tdest,
  // Control and status
  input  logic [NUM_REQ-1:0]               req_enable,
  output logic                             busy,
  output logic [$clog2(NUM_REQ)-1:0]       grant_id,
  input  logic                             stats_clear,
  output logic [NUM_REQ*STAT_WIDTH-1:0]    pkt_count
);

  localparam int IDX_W = $clog2(NUM_REQ);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0] state;

  // Per-requester views of the packed input buses
  logic [TDATA_WIDTH-1:0] req_data [NUM_REQ];
  logic [TID_WIDTH-1:0]   req_tid  [NUM_REQ];
  logic [TDEST_WIDTH-1:0] req_dest [NUM_REQ];

  // Arbitration result for the IDLE cycle
  logic [NUM_REQ-1:0] eligible;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;

  // Granted requester's beat and handshake
  logic                   sel_valid;
  logic                   sel_last;
  logic [TDATA_WIDTH-1:0] sel_data;
  logic [TID_WIDTH-1:0]   sel_tid;
  logic [TDEST_WIDTH-1:0] sel_dest;
  logic                   out_slot_free;
  logic                   accept;
  logic                   accept_last;

  // Unpack the requester buses into per-index arrays
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_data[gi] = s_axis_tdata[gi*TDATA_WIDTH +: TDATA_WIDTH];
    assign req_tid[gi]  = s_axis_tid[gi*TID_WIDTH +: TID_WIDTH];
    assign req_dest[gi] = s_axis_tdest[gi*TDEST_WIDTH +: TDEST_WIDTH];
  end

  assign eligible = s_axis_tvalid & req_enable;

  // Round-robin pick: first eligible index searching upward from grant_id+1.
  // The loop runs from the farthest offset down to the nearest one, so the
  // nearest eligible requester is written last and wins. The last-granted
  // requester sits at offset NUM_REQ, which gives it the lowest priority.
  always_comb begin
    int cand;
    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    cand       = 0;
    pick_valid = 1'b0;
    pick_idx   = grant_id;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(grant_id) + k) % NUM_REQ;
      if (eligible[IDX_W'(cand)]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  // Beat offered by the currently granted requester
  assign sel_valid = s_axis_tvalid[grant_id];
  assign sel_last  = s_axis_tlast[grant_id];
  assign sel_data  = req_data[grant_id];
  assign sel_tid   = req_tid[grant_id];
  assign sel_dest  = req_dest[grant_id];

  // The output register can take a beat when it is empty or is being drained
  assign out_slot_free = ~m_axis_tvalid | m_axis_tready;
  assign accept        = (state == ST_LOCKED) & sel_valid & out_slot_free;
  assign accept_last   = accept & sel_last;

  // Only the granted requester sees ready, and only while LOCKED
  always_comb begin
    s_axis_tready = '0;
    if (state == ST_LOCKED) begin
      s_axis_tready[grant_id] = out_slot_free;
    end
  end

  // Packet-lock FSM. The grant changes only in IDLE. In LOCKED the only exit
  // is an accepted tlast beat, so a disabled or stalled requester keeps the
  // port until its packet ends.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values and the order of blocks does not matter.
    if (!rst_n) begin
      state    <= ST_IDLE;
      grant_id <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_id <= pick_idx;
            state    <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (accept_last) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_LOCKED);

  // Output stage. It loads on accept and drains when the router takes the
  // beat. It holds its contents while stalled, which keeps the stream stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
      m_axis_tdest  <= '0;
    end else if (accept) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= sel_data;
      m_axis_tlast  <= sel_last;
      m_axis_tid    <= sel_tid;
      m_axis_tdest  <= sel_dest;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

`ifdef INJECT_ARB_STATS_EN
  localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

  logic [STAT_WIDTH-1:0] cnt_q [NUM_REQ];

  // Saturating accepted-packet counters. A clear takes priority over an
  // increment that lands in the same cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      // NOTE: this small register array is reset explicitly because software reads it; a RAM-style array holding only data would be left unreset.
      if (!rst_n || stats_clear) begin
        cnt_q[i] <= '0;
      end else if (accept_last && (grant_id == IDX_W'(i)) && (cnt_q[i] != STAT_MAX)) begin
        cnt_q[i] <= cnt_q[i] + STAT_WIDTH'(1);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat_out
    assign pkt_count[gi*STAT_WIDTH +: STAT_WIDTH] = cnt_q[gi];
  end
`else
  // The counters are not built in this configuration
  logic unused_stats_clear;
  assign unused_stats_clear = stats_clear;
  assign pkt_count          = '0;
`endif

endmodule
